// File: rtl/ft_src_arb.sv
// FTDI source arbiter: streams fixed-size packets from a CPU FIFO (priority) or a packed I/Q sample FIFO.
// Optional per-source packet counters are enabled by defining FT_SRC_ARB_STATS_EN.
module ft_src_arb #(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int PKT_WORDS        = 256,
    parameter int SIGN_EXT         = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
    input  logic                     fifo_empty_i,
    input  logic                     fifo_enough_i,
    output logic                     fifo_re_o,
    input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
    input  logic                     cpu_empty_i,
    output logic                     cpu_re_o,
    input  logic                     re_i,
    output logic [FT_DATA_WIDTH-1:0] data_o,
    output logic                     empty_o,
    output logic                     enough_o,
    output logic [1:0]               src_o,
    output logic                     underrun_o,
    output logic [15:0]              fifo_pkts_o,
    output logic [15:0]              cpu_pkts_o
);

    localparam int HALF  = IQ_PAIR_WIDTH / 2;
    localparam int CNT_W = $clog2(PKT_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PKT_WORDS - 1);
    localparam logic [FT_DATA_WIDTH-1:0] LOW_MASK =
        {FT_DATA_WIDTH{1'b1}} >> (FT_DATA_WIDTH - QSTART_BIT_INDEX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIFO = 2'd1,
        ST_CPU  = 2'd2
    } state_e;

    state_e             state_q, state_d, arb_src;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underrun_q, underrun_d;
    logic               accept;
    logic               pkt_done;

    logic [HALF-1:0]          i_val, q_val;
    logic [FT_DATA_WIDTH-1:0] i_ext, q_ext, packed_word;

    assign i_val = fifo_data_i[IQ_PAIR_WIDTH-1 -: HALF];
    assign q_val = fifo_data_i[HALF-1:0];

    // Extend each half to full width; Q keeps only the bits below I's start position.
    always_comb begin
        q_ext       = {{(FT_DATA_WIDTH-HALF){(SIGN_EXT != 0) && q_val[HALF-1]}}, q_val};
        i_ext       = {{(FT_DATA_WIDTH-HALF){(SIGN_EXT != 0) && i_val[HALF-1]}}, i_val};
        packed_word = (q_ext & LOW_MASK) | (i_ext << QSTART_BIT_INDEX);
    end

    always_comb begin
        if (!cpu_empty_i) begin
            arb_src = ST_CPU;
        end else if (fifo_enough_i) begin
            arb_src = ST_FIFO;
        end else begin
            arb_src = ST_IDLE;
        end
    end

    assign accept = re_i && (((state_q == ST_FIFO) && !fifo_empty_i) ||
                             ((state_q == ST_CPU)  && !cpu_empty_i));
    assign pkt_done = accept && (cnt_q == LAST_WORD);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q | (re_i & ~accept);
        if (state_q == ST_IDLE) begin
            state_d = arb_src;
        end else if (accept) begin
            if (pkt_done) begin
                cnt_d   = '0;
                state_d = arb_src;
            end else begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign fifo_re_o  = accept && (state_q == ST_FIFO);
    assign cpu_re_o   = accept && (state_q == ST_CPU);
    assign src_o      = state_q;
    assign underrun_o = underrun_q;

    always_comb begin
        data_o   = '0;
        empty_o  = 1'b1;
        enough_o = fifo_enough_i | !cpu_empty_i;
        case (state_q)
            ST_FIFO: begin
                data_o   = packed_word;
                empty_o  = fifo_empty_i;
                enough_o = fifo_enough_i;
            end
            ST_CPU: begin
                data_o   = cpu_data_i;
                empty_o  = cpu_empty_i;
                enough_o = !cpu_empty_i;
            end
            default: ;
        endcase
    end

`ifdef FT_SRC_ARB_STATS_EN
    logic [15:0] fifo_pkts_q, fifo_pkts_d, cpu_pkts_q, cpu_pkts_d;

    always_comb begin
        fifo_pkts_d = fifo_pkts_q;
        cpu_pkts_d  = cpu_pkts_q;
        if (pkt_done && (state_q == ST_FIFO)) begin
            fifo_pkts_d = fifo_pkts_q + 16'd1;
        end
        if (pkt_done && (state_q == ST_CPU)) begin
            cpu_pkts_d = cpu_pkts_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            fifo_pkts_q <= '0;
            cpu_pkts_q  <= '0;
        end else begin
            fifo_pkts_q <= fifo_pkts_d;
            cpu_pkts_q  <= cpu_pkts_d;
        end
    end

    assign fifo_pkts_o = fifo_pkts_q;
    assign cpu_pkts_o  = cpu_pkts_q;
`else
    assign fifo_pkts_o = '0;
    assign cpu_pkts_o  = '0;
`endif

endmodule

// File: tb/tb_ft_src_arb.sv
// Bench for ft_src_arb: directed packet scenarios with a read-word scoreboard ({src, data} per strobe).
module tb_ft_src_arb;

    localparam int W = 32;
`ifdef FT_SRC_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [23:0]   fifo_data;
    logic          fifo_empty, fifo_enough, cpu_empty, re_i;
    logic [W-1:0]  cpu_data;

    logic          fifo_re, cpu_re, empty, enough, underrun;
    logic [W-1:0]  data;
    logic [1:0]    src;
    logic [15:0]   fifo_pkts, cpu_pkts;

    logic          sx_fifo_re, sx_cpu_re, sx_empty, sx_enough, sx_underrun;
    logic [W-1:0]  sx_data;
    logic [1:0]    sx_src;
    logic [15:0]   sx_fifo_pkts, sx_cpu_pkts;

    int checks   = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];

    always #5 clk = ~clk;

    ft_src_arb #(.PKT_WORDS(4), .SIGN_EXT(0)) dut (
        .clk_i(clk), .reset_n(reset_n),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_enough_i(fifo_enough),
        .fifo_re_o(fifo_re), .cpu_data_i(cpu_data), .cpu_empty_i(cpu_empty),
        .cpu_re_o(cpu_re), .re_i(re_i), .data_o(data), .empty_o(empty),
        .enough_o(enough), .src_o(src), .underrun_o(underrun),
        .fifo_pkts_o(fifo_pkts), .cpu_pkts_o(cpu_pkts)
    );

    ft_src_arb #(.PKT_WORDS(4), .SIGN_EXT(1)) dut_sx (
        .clk_i(clk), .reset_n(reset_n),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_enough_i(fifo_enough),
        .fifo_re_o(sx_fifo_re), .cpu_data_i(cpu_data), .cpu_empty_i(cpu_empty),
        .cpu_re_o(sx_cpu_re), .re_i(re_i), .data_o(sx_data), .empty_o(sx_empty),
        .enough_o(sx_enough), .src_o(sx_src), .underrun_o(sx_underrun),
        .fifo_pkts_o(sx_fifo_pkts), .cpu_pkts_o(sx_cpu_pkts)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read strobe consumes one expected {src, data} entry.
    always @(negedge clk) begin
        if (fifo_re || cpu_re) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: got src=%0d data=%0h with empty queue", src, data);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                if ({src, data} !== e) begin
                    failures++;
                    $display("FAIL read_word: got src=%0d data=%0h expected src=%0d data=%0h",
                             src, data, e[W+1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        re_i        = 1'b1;
        fifo_data   = 24'hABC123;
        fifo_empty  = 1'b0;
        fifo_enough = 1'b1;
        cpu_data    = '0;
        cpu_empty   = 1'b1;

        // Reset state with sources ready and re_i high
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src", src, 0);
        chk("rst_data", data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_fifo_re", fifo_re, 0);
        chk("rst_cpu_re", cpu_re, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_enough", enough, 1);
        chk("rst_fifo_pkts", fifo_pkts, 0);
        chk("rst_cpu_pkts", cpu_pkts, 0);
        re_i    = 1'b0;
        reset_n = 1'b1;
        next_cycle();
        chk("release_src", src, 1);

        // FIFO-only: three back-to-back packets, last one with sign-extension pattern
        for (int i = 0; i < 8; i++) exp_q.push_back({2'd1, 32'h0ABC0123});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 32'h08000FFF});
        re_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) fifo_data = 24'h800FFF;
            @(negedge clk);
            chk("b_fifo_re", fifo_re, 1);
            chk("b_cpu_re", cpu_re, 0);
            chk("b_src", src, 1);
            if (i >= 8) chk("b_sx_data", sx_data, 32'hF800FFFF);
            next_cycle();
        end
        chk("b_fifo_pkts", fifo_pkts, 3 * STATS);

        // CPU becomes ready at FIFO word 2: switch only after word 3, no gap
        fifo_data = 24'hABC123;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 32'h0ABC0123});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 32'hC0DE0000 + 32'(i)});
        for (int j = 0; j < 8; j++) begin
            if (j == 2) cpu_empty = 1'b0;
            cpu_data = (j >= 4) ? 32'hC0DE0000 + 32'(j - 4) : 32'hDEAD0000;
            @(negedge clk);
            chk("c_strobe", fifo_re | cpu_re, 1);
            chk("c_src", src, (j < 4) ? 1 : 2);
            chk("c_cpu_re", cpu_re, (j >= 4) ? 1 : 0);
            if (j == 7) chk("c_cpu_pkts_before", cpu_pkts, 0);
            next_cycle();
        end
        chk("c_cpu_pkts_after", cpu_pkts, STATS);
        chk("c_fifo_pkts", fifo_pkts, 4 * STATS);
        chk("c_src_rearb", src, 2);
        chk("c_no_underrun", underrun, 0);

        // Reset in the middle of a CPU packet (at word 2)
        exp_q.push_back({2'd2, 32'hC0DE0100});
        exp_q.push_back({2'd2, 32'hC0DE0101});
        for (int k = 0; k < 2; k++) begin
            cpu_data = 32'hC0DE0100 + 32'(k);
            @(negedge clk);
            chk("e_cpu_re", cpu_re, 1);
            next_cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("e_src", src, 0);
        chk("e_cpu_re_rst", cpu_re, 0);
        chk("e_fifo_re_rst", fifo_re, 0);
        chk("e_data", data, 0);
        chk("e_empty", empty, 1);
        chk("e_cpu_pkts", cpu_pkts, 0);
        chk("e_fifo_pkts", fifo_pkts, 0);
        cpu_empty   = 1'b1;
        fifo_enough = 1'b0;
        re_i        = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        chk("e_idle_after", src, 0);

        // Read attempts in IDLE: sticky underrun, no strobes
        re_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("f_fifo_re", fifo_re, 0);
            chk("f_cpu_re", cpu_re, 0);
            chk("f_src", src, 0);
            next_cycle();
        end
        chk("f_underrun", underrun, 1);
        re_i = 1'b0;
        repeat (3) next_cycle();
        chk("f_underrun_sticky", underrun, 1);
        chk("f_src_hold", src, 0);

        // FIFO stalls after word 1, resumes at word 2; packet still 4 words
        fifo_data   = 24'h123456;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 32'h01230456});
        fifo_enough = 1'b1;
        next_cycle();
        chk("g_src_fifo", src, 1);
        fifo_enough = 1'b0;
        re_i        = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("g_fifo_re", fifo_re, 1);
            next_cycle();
        end
        fifo_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("g_stall_re", fifo_re, 0);
            chk("g_stall_src", src, 1);
            chk("g_stall_empty", empty, 1);
            chk("g_stall_enough", enough, 0);
            next_cycle();
        end
        fifo_empty = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("g_resume_re", fifo_re, 1);
            chk("g_resume_src", src, 1);
            next_cycle();
        end
        chk("g_idle_end", src, 0);
        chk("g_fifo_pkts", fifo_pkts, STATS);
        re_i = 1'b0;

        repeat (2) next_cycle();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
